// File: rtl/t_ff_pkg.sv
// ============================================================================
// Module   : t_ff_pkg
// Brief    : Shared mode encoding for the T-FF bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

package t_ff_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_IND  = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

endpackage : t_ff_pkg

`default_nettype wire

// File: rtl/t_ff_cell.sv
// ============================================================================
// Module   : t_ff_cell
// Brief    : Single toggle flip-flop with async reset value, sync clear/load.
// Revision : 1.0
// ============================================================================
`default_nettype none

module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic clr,
    input  logic load,
    input  logic d,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= rst_val;
        end else if (clr) begin
            q <= 1'b0;
        end else if (load) begin
            q <= d;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule : t_ff_cell

`default_nettype wire

// File: rtl/t_ff_bank.sv
// ============================================================================
// Module   : t_ff_bank
// Brief    : Bank of T-FF cells usable as independent toggles or an up/down
//            counter, with terminal count, wrap pulse and sticky overflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module t_ff_bank
    import t_ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  t,
    input  logic              en,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  q,
    output logic              tc,
    output logic              wrap,
    output logic              ovf
);

    mode_e            mode_s;
    logic [WIDTH-1:0] tog;
    logic             carry;
    logic             all_ones;
    logic             all_zero;
    logic             wrap_next;

    assign mode_s   = mode_e'(mode);
    assign all_ones = &q;
    assign all_zero = ~|q;

    // Ripple enable: bit i toggles only when every lower bit is at its
    // terminal value (1 counting up, 0 counting down).
    always_comb begin
        tog       = '0;
        carry     = en;
        wrap_next = 1'b0;
        case (mode_s)
            MODE_IND: begin
                tog = t;
            end
            MODE_UP: begin
                for (int i = 0; i < WIDTH; i++) begin
                    tog[i] = carry;
                    carry  = carry & q[i];
                end
                wrap_next = en & all_ones;
            end
            MODE_DOWN: begin
                for (int i = 0; i < WIDTH; i++) begin
                    tog[i] = carry;
                    carry  = carry & ~q[i];
                end
                wrap_next = en & all_zero;
            end
            default: begin
                tog = '0;
            end
        endcase
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            t_ff_cell u_cell (
                .clk     (clk),
                .rst     (rst),
                .rst_val (RESET_VAL[i]),
                .clr     (clr),
                .load    (load),
                .d       (din[i]),
                .t       (tog[i]),
                .q       (q[i])
            );
        end
    endgenerate

    // Load suppresses the count, so it can never produce a wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (clr) begin
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
            if (wrap_next) begin
                ovf <= 1'b1;
            end
        end
    end

    assign tc = ((mode_s == MODE_UP)   && all_ones) ||
                ((mode_s == MODE_DOWN) && all_zero);

endmodule : t_ff_bank

`default_nettype wire

// File: tb/tb_t_ff_bank.sv
// ============================================================================
// Module   : tb_t_ff_bank
// Brief    : Self-checking bench for t_ff_bank (WIDTH=4) with a scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_t_ff_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic [3:0] t;
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] din;
    logic [3:0] q;
    logic       tc;
    logic       wrap;
    logic       ovf;
    logic [3:0] q_rv;
    logic       tc_rv;
    logic       wrap_rv;
    logic       ovf_rv;

    always #5 clk = ~clk;

    t_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0000)) dut (
        .clk  (clk),  .rst  (rst),  .mode (mode), .t    (t),
        .en   (en),   .clr  (clr),  .load (load), .din  (din),
        .q    (q),    .tc   (tc),   .wrap (wrap), .ovf  (ovf)
    );

    t_ff_bank #(.WIDTH(4), .RESET_VAL(4'b0101)) dut_rv (
        .clk  (clk),  .rst  (rst),  .mode (mode), .t    (t),
        .en   (en),   .clr  (clr),  .load (load), .din  (din),
        .q    (q_rv), .tc   (tc_rv), .wrap (wrap_rv), .ovf (ovf_rv)
    );

    typedef struct {
        string      tag;
        logic [3:0] q;
        logic       tc;
        logic       wrap;
        logic       ovf;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [3:0] mq;
    logic       movf;

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = sb.pop_front();
        cmp({e.tag, ".q"},    q,    e.q);
        cmp({e.tag, ".tc"},   {3'b0, tc},   {3'b0, e.tc});
        cmp({e.tag, ".wrap"}, {3'b0, wrap}, {3'b0, e.wrap});
        cmp({e.tag, ".ovf"},  {3'b0, ovf},  {3'b0, e.ovf});
    endtask

    // Drive one clock of stimulus, predict the result arithmetically, then check.
    task automatic step(input string tag, input logic c, input logic l, input logic [3:0] d,
                        input logic [1:0] m, input logic [3:0] tv, input logic e);
        exp_t       x;
        logic [3:0] nq;
        logic       nw;
        @(negedge clk);
        clr = c; load = l; din = d; mode = m; t = tv; en = e;
        nw = 1'b0;
        nq = mq;
        if (c) begin
            nq   = 4'd0;
            movf = 1'b0;
        end else if (l) begin
            nq = d;
        end else begin
            case (m)
                2'b00: nq = mq ^ tv;
                2'b01: if (e) begin nq = mq + 4'd1; nw = (mq == 4'hF); end
                2'b10: if (e) begin nq = mq - 4'd1; nw = (mq == 4'h0); end
                default: nq = mq;
            endcase
        end
        movf   = movf | nw;
        x.tag  = tag;
        x.q    = nq;
        x.wrap = nw;
        x.ovf  = movf;
        x.tc   = ((m == 2'b01) && (nq == 4'hF)) || ((m == 2'b10) && (nq == 4'h0));
        sb.push_back(x);
        mq = nq;
        @(posedge clk);
        #1;
        check_pop();
    endtask

    task automatic expect_reset(input string tag);
        exp_t x;
        mq     = 4'd0;
        movf   = 1'b0;
        x.tag  = tag;
        x.q    = 4'd0;
        x.tc   = 1'b0;
        x.wrap = 1'b0;
        x.ovf  = 1'b0;
        sb.push_back(x);
        check_pop();
        cmp({tag, ".q_rv"},    q_rv, 4'b0101);
        cmp({tag, ".wrap_rv"}, {3'b0, wrap_rv}, 4'd0);
        cmp({tag, ".ovf_rv"},  {3'b0, ovf_rv},  4'd0);
    endtask

    initial begin
        rst = 1'b0; mode = 2'b11; t = '0; en = 1'b0; clr = 1'b0; load = 1'b0; din = '0;
        mq = '0; movf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_reset("reset");
        @(negedge clk);
        rst = 1'b1;

        // Independent toggling; en flips each step and must not matter.
        step("ind0", 0, 0, 4'h0, 2'b00, 4'b0101, 1'b1);
        cmp("ind0_lit", q, 4'b0101);
        step("ind1", 0, 0, 4'h0, 2'b00, 4'b0101, 1'b0);
        cmp("ind1_lit", q, 4'b0000);
        step("ind2", 0, 0, 4'h0, 2'b00, 4'b0101, 1'b1);
        cmp("ind2_lit", q, 4'b0101);

        // Count up through the wrap.
        step("up_load", 0, 1, 4'b1110, 2'b01, 4'h0, 1'b1);
        step("up_ff",   0, 0, 4'h0,    2'b01, 4'h0, 1'b1);
        cmp("up_tc_lit", {3'b0, tc}, 4'd1);
        step("up_wrap", 0, 0, 4'h0,    2'b01, 4'h0, 1'b1);
        cmp("up_wrap_lit", {3'b0, wrap}, 4'd1);
        step("up_post", 0, 0, 4'h0,    2'b01, 4'h0, 1'b1);
        cmp("up_post_lit", {q, 1'b0, 1'b0, wrap, ovf} >> 3, {4'b0001, 1'b0} >> 0);

        // Loading all-ones in up mode must not wrap; then count to 1010.
        step("ld_ones",  0, 1, 4'b1111, 2'b01, 4'h0, 1'b1);
        step("ld_pre",   0, 1, 4'b0000, 2'b01, 4'h0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step("up_run", 0, 0, 4'h0, 2'b01, 4'h0, 1'b1);
        end
        cmp("up_run_lit", q, 4'b1010);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b0; mode = 2'b11; en = 1'b0;
        #1;
        expect_reset("async_rst");
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 0, 0, 4'h0, 2'b01, 4'h0, 1'b1);
        cmp("post_rst_lit", q, 4'b0001);

        // Count down through the wrap; tc independent of en.
        step("dn_load", 0, 1, 4'b0001, 2'b10, 4'h0, 1'b1);
        step("dn_zero", 0, 0, 4'h0,    2'b10, 4'h0, 1'b1);
        step("dn_tc_en0", 0, 0, 4'h0,  2'b10, 4'h0, 1'b0);
        step("dn_wrap", 0, 0, 4'h0,    2'b10, 4'h0, 1'b1);
        cmp("dn_wrap_lit", q, 4'b1111);

        // Hold and disabled counting.
        for (int i = 0; i < 4; i++) begin
            step("hold", 0, 0, 4'h0, 2'b11, 4'b1111, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            step("up_en0", 0, 0, 4'h0, 2'b01, 4'b1111, 1'b0);
        end
        cmp("hold_lit", q, 4'b1111);

        // Clear beats load and a pending wrap; then plain load with no count.
        step("pr_clr",  1, 1, 4'b1001, 2'b01, 4'h0, 1'b1);
        cmp("pr_clr_ovf_lit", {3'b0, ovf}, 4'd0);
        step("pr_load", 0, 1, 4'b1001, 2'b01, 4'h0, 1'b1);
        cmp("pr_load_lit", q, 4'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_t_ff_bank

`default_nettype wire

// File: doc/t_ff_bank.md
# t_ff_bank

Parametrised bank of WIDTH toggle flip-flops that replaces single-bit T flip-flops in the datapath. Each bit can toggle independently from its own T input. The bits can also be cascaded into a synchronous up/down counter built from T-FF cells. The bank supports synchronous clear, parallel load, terminal-count detection and wrap/overflow reporting, and serves as the generic toggle/count element for control logic.

## Interface
Parameters:
- WIDTH, 8: number of T-FF cells (≥2)
- RESET_VAL, 0: value of q after reset (WIDTH bits)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- mode  in  2  00 independent toggle, 01 count up, 10 count down, 11 hold
- t  in  WIDTH  per-bit toggle enables; used only in independent mode
- en  in  1  count enable; used only in count up/down modes
- clr  in  1  synchronous clear of q and ovf
- load  in  1  synchronous parallel load of din into q
- din  in  WIDTH  load data
- q  out  WIDTH  bank state
- tc  out  1  terminal count, combinational from q and mode
- wrap  out  1  registered one-cycle pulse on counter wrap-around
- ovf  out  1  sticky wrap flag

## Operation
- Reset (rst=0): q=RESET_VAL, wrap=0, ovf=0. Takes effect immediately, with no clock edge required, and overrides all other inputs. Release is synchronised externally.
- Per-edge priority: clr > load > mode action.
- clr=1: q←0, ovf←0, wrap←0.
- load=1 (clr=0): q←din, wrap←0, ovf unchanged. There is no count or toggle in a load cycle.
- Independent (00): q[i]←q[i]^t[i]. en ignored. wrap←0.
- Count up (01): toggle vector T[0]=en, T[i]=en & (&q[i-1:0]). Result equals q+1 mod 2^WIDTH when en=1.
- Count down (10): T[0]=en, T[i]=en & ~(|q[i-1:0]). Result equals q−1 mod 2^WIDTH when en=1.
- Hold (11): q unchanged. t and en ignored. wrap←0.
- en=0 in count modes: q unchanged, wrap←0.
- wrap: set for exactly one cycle when a count edge moves q from all-ones to 0 (up) or from 0 to all-ones (down). Otherwise 0.
- ovf: set together with wrap. Stays set until clr or reset. Mode changes and load do not clear it.
- tc:
  - 1 when mode=01 and q=all-ones
  - 1 when mode=10 and q=0
  - 0 in modes 00 and 11
  - Independent of en.
- Mode changes apply at the next edge. No state is carried between modes other than q and ovf.

## Timing
- q: 1-cycle latency from sampled inputs to updated q.
- wrap and ovf: valid in the same cycle as the wrapped q value (wrap=1 while q=0 after an up wrap).
- tc: combinational, valid in the same cycle as q and mode; no register stage.
- Reset mid-count: q jumps to RESET_VAL asynchronously, and wrap and ovf drop the same instant. The first count after release starts from RESET_VAL.
- clr together with a would-be wrap: clr wins; wrap=0, ovf=0.
- load of all-ones in up mode does not raise wrap. Only a counting edge can wrap.

## Structure
- Package t_ff_pkg:
  - mode typedef/enum: MODE_IND, MODE_UP, MODE_DOWN, MODE_HOLD
  - mode width constant
- Sub-module t_ff_cell: one bit with clk, rst (async active-low), rst_val, clr, load, d, t → q.
  - Generate WIDTH instances.
  - The top level computes the toggle vector per mode and owns the wrap/ovf registers.

## Test plan
(WIDTH=4, RESET_VAL=0 unless noted)
- Async reset: count up to q=1010, drive rst=0 between edges → q=0000, wrap=0, ovf=0 before the next edge. With RESET_VAL=0101 → q=0101.
- Independent mode: from 0000, t=0101 for 3 edges → q=0101, 0000, 0101. tc=0 throughout. en toggling has no effect.
- Count up: load din=1110, then mode=01, en=1 → q=1111 with tc=1, next edge q=0000 with wrap=1 for one cycle, then q=0001 with wrap=0, ovf=1 held.
- Count down: load 0001, mode=10, en=1 → q=0000 with tc=1, next edge q=1111 with wrap=1, ovf=1.
- Hold and disable: mode=11 with t=1111 and en=1, then mode=01 with en=0, 4 edges each → q unchanged, wrap=0.
- Priority: clr=1 and load=1 with din=1001 at an up-mode wrap edge → q=0000, wrap=0, ovf=0. Next edge load=1 only, mode=01, en=1 → q=1001 with no increment.
